// File: rtl/isdu.sv
// Instruction sequencer/decoder: Moore FSM that sequences fetch, decode and execute control for the datapath.
// Build option: ISDU_MEM_WAIT_EN stretches memory reads to three cycles and the store write to two.
module isdu (
  input  logic       clk,
  input  logic       reset,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       LD_LED,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic [1:0] PCMUX,
  output logic       DRMUX,
  output logic       SR1MUX,
  output logic       SR2MUX,
  output logic       ADDR1MUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] ALUK,
  output logic       Mem_OE,
  output logic       Mem_WE
);

  typedef enum logic [4:0] {
    HALTED, S_18, S_33_1, S_33_2, S_33_3, S_35, S_32,
    S_01, S_05, S_09, S_00, S_22, S_12, S_04, S_21,
    S_06, S_07, S_25_1, S_25_2, S_25_3, S_27, S_23,
    S_16_1, S_16_2, PAUSE_IR1, PAUSE_IR2
  } state_t;

  state_t state, next_state;

  // IR bit 11 does not steer the sequencer.
  logic unused_ir11;
  assign unused_ir11 = IR_11;

  assign SR2MUX = IR_5;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= HALTED;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      HALTED:    if (Run) next_state = S_18;
      S_18:      next_state = S_33_1;
`ifdef ISDU_MEM_WAIT_EN
      S_33_1:    next_state = S_33_2;
      S_33_2:    next_state = S_33_3;
      S_33_3:    next_state = S_35;
`else
      S_33_1:    next_state = S_35;
`endif
      S_35:      next_state = S_32;
      S_32: begin
        case (Opcode)
          4'b0001: next_state = S_01;
          4'b0101: next_state = S_05;
          4'b1001: next_state = S_09;
          4'b0000: next_state = S_00;
          4'b1100: next_state = S_12;
          4'b0100: next_state = S_04;
          4'b0110: next_state = S_06;
          4'b0111: next_state = S_07;
          4'b1101: next_state = PAUSE_IR1;
          default: next_state = S_18;
        endcase
      end
      S_01, S_05, S_09: next_state = S_18;
      S_00:      next_state = BEN ? S_22 : S_18;
      S_22:      next_state = S_18;
      S_12:      next_state = S_18;
      S_04:      next_state = S_21;
      S_21:      next_state = S_18;
      S_06:      next_state = S_25_1;
      S_07:      next_state = S_23;
`ifdef ISDU_MEM_WAIT_EN
      S_25_1:    next_state = S_25_2;
      S_25_2:    next_state = S_25_3;
      S_25_3:    next_state = S_27;
`else
      S_25_1:    next_state = S_27;
`endif
      S_27:      next_state = S_18;
      S_23:      next_state = S_16_1;
`ifdef ISDU_MEM_WAIT_EN
      S_16_1:    next_state = S_16_2;
      S_16_2:    next_state = S_18;
`else
      S_16_1:    next_state = S_18;
`endif
      PAUSE_IR1: if (Continue)  next_state = PAUSE_IR2;
      PAUSE_IR2: if (!Continue) next_state = S_18;
      default:   next_state = HALTED;
    endcase
  end

  always_comb begin
    LD_MAR     = 1'b0;
    LD_MDR     = 1'b0;
    LD_IR      = 1'b0;
    LD_BEN     = 1'b0;
    LD_CC      = 1'b0;
    LD_REG     = 1'b0;
    LD_PC      = 1'b0;
    LD_LED     = 1'b0;
    GatePC     = 1'b0;
    GateMDR    = 1'b0;
    GateALU    = 1'b0;
    GateMARMUX = 1'b0;
    PCMUX      = 2'b00;
    DRMUX      = 1'b0;
    SR1MUX     = 1'b0;
    ADDR1MUX   = 1'b0;
    ADDR2MUX   = 2'b00;
    ALUK       = 2'b00;
    Mem_OE     = 1'b1;
    Mem_WE     = 1'b1;
    case (state)
      S_18: begin
        GatePC = 1'b1;
        LD_MAR = 1'b1;
        PCMUX  = 2'b00;
        LD_PC  = 1'b1;
      end
      // Strobe is held across every read substate; MDR captures only once data is settled.
`ifdef ISDU_MEM_WAIT_EN
      S_33_1, S_33_2, S_25_1, S_25_2: Mem_OE = 1'b0;
      S_33_3, S_25_3: begin
        Mem_OE = 1'b0;
        LD_MDR = 1'b1;
      end
`else
      S_33_1, S_25_1: begin
        Mem_OE = 1'b0;
        LD_MDR = 1'b1;
      end
`endif
      S_35: begin
        GateMDR = 1'b1;
        LD_IR   = 1'b1;
      end
      S_32: LD_BEN = 1'b1;
      S_01, S_05, S_09: begin
        SR1MUX  = 1'b1;
        ALUK    = (state == S_01) ? 2'b00 : (state == S_05) ? 2'b01 : 2'b10;
        GateALU = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
      end
      S_22: begin
        ADDR1MUX = 1'b0;
        ADDR2MUX = 2'b10;
        PCMUX    = 2'b10;
        LD_PC    = 1'b1;
      end
      S_12: begin
        SR1MUX  = 1'b1;
        ALUK    = 2'b11;
        GateALU = 1'b1;
        PCMUX   = 2'b01;
        LD_PC   = 1'b1;
      end
      S_04: begin
        GatePC = 1'b1;
        DRMUX  = 1'b1;
        LD_REG = 1'b1;
      end
      S_21: begin
        ADDR1MUX = 1'b0;
        ADDR2MUX = 2'b11;
        PCMUX    = 2'b10;
        LD_PC    = 1'b1;
      end
      S_06, S_07: begin
        SR1MUX     = 1'b1;
        ADDR1MUX   = 1'b1;
        ADDR2MUX   = 2'b01;
        GateMARMUX = 1'b1;
        LD_MAR     = 1'b1;
      end
      S_27: begin
        GateMDR = 1'b1;
        LD_REG  = 1'b1;
        LD_CC   = 1'b1;
      end
      S_23: begin
        SR1MUX  = 1'b0;
        ALUK    = 2'b11;
        GateALU = 1'b1;
        LD_MDR  = 1'b1;
      end
      S_16_1, S_16_2: Mem_WE = 1'b0;
      PAUSE_IR1: LD_LED = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_isdu.sv
// Self-checking bench for isdu: random instruction streams against a per-instruction control-word model.
module tb_isdu;

  logic       clk = 1'b0;
  logic       reset, Run, Continue;
  logic [3:0] Opcode;
  logic       IR_5, IR_11, BEN;
  logic       LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED;
  logic       GatePC, GateMDR, GateALU, GateMARMUX;
  logic [1:0] PCMUX, ADDR2MUX, ALUK;
  logic       DRMUX, SR1MUX, SR2MUX, ADDR1MUX, Mem_OE, Mem_WE;

  isdu dut (
    .clk(clk), .reset(reset), .Run(Run), .Continue(Continue),
    .Opcode(Opcode), .IR_5(IR_5), .IR_11(IR_11), .BEN(BEN),
    .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN),
    .LD_CC(LD_CC), .LD_REG(LD_REG), .LD_PC(LD_PC), .LD_LED(LD_LED),
    .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU), .GateMARMUX(GateMARMUX),
    .PCMUX(PCMUX), .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX),
    .ADDR1MUX(ADDR1MUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK),
    .Mem_OE(Mem_OE), .Mem_WE(Mem_WE)
  );

  always #5 clk = ~clk;

  // Control word; OE/WE bits in the model mean "strobe asserted" and are inverted before comparing.
  logic [22:0] obs;
  assign obs = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED,
                GatePC, GateMDR, GateALU, GateMARMUX, PCMUX, DRMUX, SR1MUX,
                ADDR1MUX, ADDR2MUX, ALUK, Mem_OE, Mem_WE};

  localparam logic [22:0] M_LD_MAR  = 23'd1 << 22;
  localparam logic [22:0] M_LD_MDR  = 23'd1 << 21;
  localparam logic [22:0] M_LD_IR   = 23'd1 << 20;
  localparam logic [22:0] M_LD_BEN  = 23'd1 << 19;
  localparam logic [22:0] M_LD_CC   = 23'd1 << 18;
  localparam logic [22:0] M_LD_REG  = 23'd1 << 17;
  localparam logic [22:0] M_LD_PC   = 23'd1 << 16;
  localparam logic [22:0] M_LD_LED  = 23'd1 << 15;
  localparam logic [22:0] M_G_PC    = 23'd1 << 14;
  localparam logic [22:0] M_G_MDR   = 23'd1 << 13;
  localparam logic [22:0] M_G_ALU   = 23'd1 << 12;
  localparam logic [22:0] M_G_MARM  = 23'd1 << 11;
  localparam logic [22:0] M_PC_BUS  = 23'd1 << 9;
  localparam logic [22:0] M_PC_ADD  = 23'd2 << 9;
  localparam logic [22:0] M_DR_R7   = 23'd1 << 8;
  localparam logic [22:0] M_SR1_86  = 23'd1 << 7;
  localparam logic [22:0] M_A1_SR1  = 23'd1 << 6;
  localparam logic [22:0] M_A2_S6   = 23'd1 << 4;
  localparam logic [22:0] M_A2_S9   = 23'd2 << 4;
  localparam logic [22:0] M_A2_S11  = 23'd3 << 4;
  localparam logic [22:0] M_K_AND   = 23'd1 << 2;
  localparam logic [22:0] M_K_NOT   = 23'd2 << 2;
  localparam logic [22:0] M_K_PASS  = 23'd3 << 2;
  localparam logic [22:0] M_OE      = 23'd1 << 1;
  localparam logic [22:0] M_WE      = 23'd1;
  localparam logic [22:0] STROBES   = 23'h3;

  localparam logic [22:0] W_FETCH = M_G_PC | M_LD_MAR | M_LD_PC;
  localparam logic [22:0] W_ALU   = M_SR1_86 | M_G_ALU | M_LD_REG | M_LD_CC;
  localparam logic [22:0] W_EA    = M_SR1_86 | M_A1_SR1 | M_A2_S6 | M_G_MARM | M_LD_MAR;

`ifdef ISDU_MEM_WAIT_EN
  localparam int FETCH_LEN = 6;
  localparam int LDR_EXEC  = 5;
`else
  localparam int FETCH_LEN = 4;
  localparam int LDR_EXEC  = 3;
`endif

  int errors = 0;
  int checks = 0;
  logic [22:0] exp_q[$];

  task automatic push_read();
`ifdef ISDU_MEM_WAIT_EN
    exp_q.push_back(M_OE);
    exp_q.push_back(M_OE);
`endif
    exp_q.push_back(M_OE | M_LD_MDR);
  endtask

  // One instruction as a list of per-cycle control words, starting at its fetch.
  task automatic model_instr(input logic [3:0] op, input logic ben);
    exp_q.push_back(W_FETCH);
    push_read();
    exp_q.push_back(M_G_MDR | M_LD_IR);
    exp_q.push_back(M_LD_BEN);
    case (op)
      4'b0001: exp_q.push_back(W_ALU);
      4'b0101: exp_q.push_back(W_ALU | M_K_AND);
      4'b1001: exp_q.push_back(W_ALU | M_K_NOT);
      4'b0000: begin
        exp_q.push_back(23'd0);
        if (ben) exp_q.push_back(M_A2_S9 | M_PC_ADD | M_LD_PC);
      end
      4'b1100: exp_q.push_back(M_SR1_86 | M_K_PASS | M_G_ALU | M_PC_BUS | M_LD_PC);
      4'b0100: begin
        exp_q.push_back(M_G_PC | M_DR_R7 | M_LD_REG);
        exp_q.push_back(M_A2_S11 | M_PC_ADD | M_LD_PC);
      end
      4'b0110: begin
        exp_q.push_back(W_EA);
        push_read();
        exp_q.push_back(M_G_MDR | M_LD_REG | M_LD_CC);
      end
      4'b0111: begin
        exp_q.push_back(W_EA);
        exp_q.push_back(M_K_PASS | M_G_ALU | M_LD_MDR);
        exp_q.push_back(M_WE);
`ifdef ISDU_MEM_WAIT_EN
        exp_q.push_back(M_WE);
`endif
      end
      default: ;
    endcase
  endtask

  task automatic do_reset();
    reset = 1'b1; Run = 1'b0; Continue = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic start_run();
    Run = 1'b1;
    @(posedge clk); #1;
    Run = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; Run = 1'b0; Continue = 1'b0; Opcode = 4'b0001; BEN = 1'b0; IR_5 = 1'b1;
    #1;
    checks++;
    if (obs !== STROBES) begin
      errors++; $display("FAIL reset_idle got %h want %h", obs, STROBES);
    end
    checks++;
    if (SR2MUX !== 1'b1) begin
      errors++; $display("FAIL reset_sr2mux got %b want 1", SR2MUX);
    end
    @(posedge clk); #1;
    reset = 1'b0; IR_5 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== STROBES || SR2MUX !== 1'b0) begin
        errors++; $display("FAIL halted_hold cyc%0d got %h/%b want %h/0", i, obs, SR2MUX, STROBES);
      end
      @(posedge clk); #1;
    end
    start_run();
    @(negedge clk);
    checks++;
    if (obs !== (W_FETCH ^ STROBES)) begin
      errors++; $display("FAIL run_start got %h want %h", obs, W_FETCH ^ STROBES);
    end
  endtask

  task automatic test_add();
    do_reset();
    Opcode = 4'b0001; BEN = 1'b0; IR_5 = 1'(($urandom) & 1);
    start_run();
    exp_q.delete();
    model_instr(4'b0001, 1'b0);
    exp_q.push_back(W_FETCH);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      checks++;
      if (obs !== (exp_q[i] ^ STROBES)) begin
        errors++; $display("FAIL add cyc%0d got %h want %h", i, obs, exp_q[i] ^ STROBES);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch();
    for (int b = 0; b < 2; b++) begin
      do_reset();
      Opcode = 4'b0000; BEN = 1'(b);
      start_run();
      exp_q.delete();
      model_instr(4'b0000, 1'(b));
      exp_q.push_back(W_FETCH);
      for (int i = 0; i < exp_q.size(); i++) begin
        @(negedge clk);
        checks++;
        if (obs !== (exp_q[i] ^ STROBES)) begin
          errors++; $display("FAIL br_ben%0d cyc%0d got %h want %h", b, i, obs, exp_q[i] ^ STROBES);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_store();
    do_reset();
    Opcode = 4'b0111; BEN = 1'b1;
    start_run();
    exp_q.delete();
    model_instr(4'b0111, 1'b1);
    exp_q.push_back(W_FETCH);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      checks++;
      if (obs !== (exp_q[i] ^ STROBES)) begin
        errors++; $display("FAIL str cyc%0d got %h want %h", i, obs, exp_q[i] ^ STROBES);
      end
      if (i >= FETCH_LEN) begin
        checks++;
        if (Mem_OE !== 1'b1) begin
          errors++; $display("FAIL str_oe cyc%0d got %b want 1", i, Mem_OE);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_pause();
    do_reset();
    Opcode = 4'b1101;
    start_run();
    exp_q.delete();
    model_instr(4'b1101, 1'b0);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      checks++;
      if (obs !== (exp_q[i] ^ STROBES)) begin
        errors++; $display("FAIL pause_fetch cyc%0d got %h want %h", i, obs, exp_q[i] ^ STROBES);
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 6; i++) begin
      if (i == 5) Continue = 1'b1;
      @(negedge clk);
      checks++;
      if (obs !== (M_LD_LED ^ STROBES)) begin
        errors++; $display("FAIL pause1 cyc%0d got %h want %h", i, obs, M_LD_LED ^ STROBES);
      end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 2; i++) begin
      if (i == 1) Continue = 1'b0;
      @(negedge clk);
      checks++;
      if (obs !== STROBES) begin
        errors++; $display("FAIL pause2 cyc%0d got %h want %h", i, obs, STROBES);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    checks++;
    if (obs !== (W_FETCH ^ STROBES)) begin
      errors++; $display("FAIL pause_resume got %h want %h", obs, W_FETCH ^ STROBES);
    end
  endtask

  task automatic test_ldr_reset();
    int cnt;
    do_reset();
    Opcode = 4'b0110;
    start_run();
    exp_q.delete();
    model_instr(4'b0110, 1'b0);
    // Walk fetch and address phase, then land in the first load-read cycle.
    for (int i = 0; i <= FETCH_LEN + 1; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== (exp_q[i] ^ STROBES)) begin
        errors++; $display("FAIL ldr cyc%0d got %h want %h", i, obs, exp_q[i] ^ STROBES);
      end
      if (i <= FETCH_LEN) begin
        @(posedge clk); #1;
      end
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if (obs !== STROBES) begin
      errors++; $display("FAIL ldr_reset got %h want %h", obs, STROBES);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (obs !== STROBES) begin
        errors++; $display("FAIL post_reset cyc%0d got %h want %h", i, obs, STROBES);
      end
      @(posedge clk); #1;
    end
    start_run();
    for (int i = 0; i < FETCH_LEN; i++) begin
      @(posedge clk); #1;
    end
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (obs === (W_FETCH ^ STROBES)) break;
      cnt++;
      @(posedge clk); #1;
    end
    checks++;
    if (cnt != LDR_EXEC) begin
      errors++; $display("FAIL ldr_latency got %0d want %0d", cnt, LDR_EXEC);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] op;
    logic       ben;
    do_reset();
    start_run();
    for (int n = 0; n < 60; n++) begin
      op  = 4'($urandom_range(15));
      if (op == 4'b1101) op = 4'b0101;
      ben = 1'(($urandom) & 1);
      Opcode = op; BEN = ben; IR_5 = 1'(($urandom) & 1); IR_11 = 1'(($urandom) & 1);
      exp_q.delete();
      model_instr(op, ben);
      for (int i = 0; i < exp_q.size(); i++) begin
        @(negedge clk);
        checks++;
        if (obs !== (exp_q[i] ^ STROBES) || SR2MUX !== IR_5) begin
          errors++;
          $display("FAIL b2b op%h n%0d cyc%0d got %h/%b want %h/%b",
                   op, n, i, obs, SR2MUX, exp_q[i] ^ STROBES, IR_5);
        end
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    IR_11 = 1'b0;
    test_reset();
    test_add();
    test_branch();
    test_store();
    test_pause();
    test_ldr_reset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/isdu.md
ISDU -- requirements
Module: isdu

Interface
REQ-001 Parameters: none; the only build option is the macro in Configuration.
REQ-002 clk  in  1  single rising-edge clock.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 Run, Continue  in  1 each  level inputs from the board, already synchronized.
REQ-005 Opcode  in  4  IR[15:12]; IR_5, IR_11  in  1 each  IR bit 5 and IR bit 11.
REQ-006 BEN  in  1  branch-enable bit held by the datapath.
REQ-007 LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC, LD_LED  out  1 each  datapath register loads.
REQ-008 GatePC, GateMDR, GateALU, GateMARMUX  out  1 each  bus drivers, at most one high per cycle.
REQ-009 PCMUX  out  2  PC source: 00 = PC+1, 01 = bus, 10 = address adder.
REQ-010 DRMUX, SR1MUX, SR2MUX, ADDR1MUX  out  1 each  DRMUX 1 = R7; SR1MUX 1 = IR[8:6]; SR2MUX 1 = SEXT5; ADDR1MUX 1 = SR1.
REQ-011 ADDR2MUX  out  2  address offset: 00 = 0, 01 = SEXT6, 10 = SEXT9, 11 = SEXT11.
REQ-012 ALUK  out  2  ALU operation: 00 = ADD, 01 = AND, 10 = NOT, 11 = PASS A.
REQ-013 Mem_OE, Mem_WE  out  1 each  memory strobes, active-low.

Function
REQ-014 The block is a Moore FSM: all outputs decode from the state register only, except SR2MUX, which equals IR_5.
REQ-015 Any output not asserted by a state is 0, or 1 for Mem_OE and Mem_WE.
REQ-016 Halted: all outputs idle; the FSM moves to S_18 when Run = 1.
REQ-017 S_18: GatePC, LD_MAR, PCMUX = 00, LD_PC; next state is S_33.
REQ-018 S_33: Mem_OE = 0 and LD_MDR; next state is S_35.
REQ-019 S_35: GateMDR and LD_IR; next state is S_32.
REQ-020 S_32: LD_BEN; dispatch on Opcode.
- 0001 -> S_01; 0101 -> S_05; 1001 -> S_09; 0000 -> S_00
- 1100 -> S_12; 0100 -> S_04; 0110 -> S_06; 0111 -> S_07
- 1101 -> PauseIR1; any other opcode -> S_18.
REQ-021 S_01 / S_05 / S_09: SR1MUX = 1, ALUK = 00 / 01 / 10, GateALU, LD_REG, LD_CC; next state is S_18.
REQ-022 S_00: next state is S_22 if BEN = 1, else S_18.
REQ-023 S_22: ADDR1MUX = 0, ADDR2MUX = 10, PCMUX = 10, LD_PC; next state is S_18.
REQ-024 S_12: SR1MUX = 1, ALUK = 11, GateALU, PCMUX = 01, LD_PC; next state is S_18.
REQ-025 S_04: GatePC, DRMUX = 1, LD_REG; next state is S_21.
REQ-026 S_21: ADDR1MUX = 0, ADDR2MUX = 11, PCMUX = 10, LD_PC; next state is S_18.
- IR_11 is an input only; JSRR is not implemented.
REQ-027 S_06 / S_07: SR1MUX = 1, ADDR1MUX = 1, ADDR2MUX = 01, GateMARMUX, LD_MAR; next state is S_25 / S_23.
REQ-028 S_25: Mem_OE = 0 and LD_MDR; next state is S_27.
REQ-029 S_27: GateMDR, LD_REG, LD_CC; next state is S_18.
REQ-030 S_23: SR1MUX = 0, ALUK = 11, GateALU, LD_MDR; next state is S_16.
REQ-031 S_16: Mem_WE = 0; next state is S_18.
REQ-032 PauseIR1: LD_LED = 1; the FSM holds until Continue = 1, then moves to PauseIR2.
REQ-033 PauseIR2: the FSM holds until Continue = 0, then moves to S_18.
- Each Continue press therefore advances exactly one instruction.
REQ-034 Run is sampled only in Halted; deasserting Run elsewhere has no effect.

Reset
REQ-035 Asserting reset forces Halted immediately, mid-instruction included, and all outputs go to their idle values within the same cycle.
REQ-036 After reset is released, the FSM leaves Halted only on a rising clock edge with Run = 1.

Configuration
REQ-037 ISDU_MEM_WAIT_EN defined: each memory read state is three cycles (S_33 and S_25 become _1/_2/_3).
- LD_MDR is asserted only in the _3 substate.
- S_16 becomes S_16_1/S_16_2, with Mem_WE = 0 in both.
REQ-038 ISDU_MEM_WAIT_EN undefined: each memory read and write state is one cycle, as specified in REQ-018, REQ-028 and REQ-031.

Verification
REQ-039 Reset, then Run = 1 for one cycle, Opcode = 0001 -> state sequence Halted, S_18, S_33, S_35, S_32, S_01, S_18; in S_01, ALUK = 00, LD_REG = 1, LD_CC = 1.
REQ-040 Opcode = 0000 with BEN = 0 -> S_00 then S_18 with LD_PC never asserted; with BEN = 1 -> S_22 with PCMUX = 10 and ADDR2MUX = 10.
REQ-041 Opcode = 0111 -> S_07, S_23, S_16; Mem_WE = 0 only in S_16; Mem_OE = 1 throughout the execute phase.
REQ-042 Opcode = 1101, Continue held 0 for 5 cycles -> PauseIR1 held with LD_LED = 1; Continue 1 then 0 -> PauseIR2, then S_18.
REQ-043 Reset asserted during S_25 -> Halted on the same cycle with Mem_OE = 1 and all loads 0; with ISDU_MEM_WAIT_EN, LDR takes 2 cycles longer than without.
